// File: rtl/car_game_pkg.sv
// Shared definitions for the car game obstacle logic.
//   X_W / Y_W       screen coordinate widths (X 10 bits, Y 9 bits)
//   SLOT_IDLE/...   per-slot state encoding
//   lane_of()       maps a 9-bit random X onto one of num_lanes lanes
//   lane_centre()   X coordinate of a lane centre
//   y_dist()        absolute difference of two Y coordinates
package car_game_pkg;

    localparam int X_W = 10;
    localparam int Y_W = 9;

    localparam logic [0:0] SLOT_IDLE   = 1'b0;
    localparam logic [0:0] SLOT_ACTIVE = 1'b1;

    // (rand_x * num_lanes) >> 9; num_lanes <= 4 keeps the product below 2^11
    function automatic logic [1:0] lane_of(input logic [8:0] rand_x, input int num_lanes);
        logic [11:0] prod;
        prod = 12'(rand_x) * 12'(num_lanes);
        return prod[10:9];
    endfunction

    function automatic logic [X_W-1:0] lane_centre(input logic [1:0] lane,
                                                   input int lane0_x,
                                                   input int lane_pitch);
        int x;
        x = lane0_x + int'(lane) * lane_pitch;
        return X_W'(x);
    endfunction

    function automatic logic [Y_W-1:0] y_dist(input logic [Y_W-1:0] a, input logic [Y_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/obstacle_car_bank_if.sv
// Bus between the game FSM / random generator (master) and the obstacle
// car bank (slave).
//   iSpawn/iRandX         spawn request pulse and random X
//   iTick/iSpeed          frame tick pulse and pixels per tick
//   iSalto                synchronous global clear
//   oPosX/oPosY/oActive   packed per-slot position and valid flags
//   oSpawnAck/oSpawnRej   spawn outcome pulses
//   oPassCount           saturating count of cars retired off screen
// Macro OBSTACLE_COLLISION_EN adds iPlayerX, iPlayerY and oHit.
interface obstacle_car_bank_if #(
    parameter int NUM_CARS = 4,
    parameter int SPEED_W  = 4,
    parameter int CNT_W    = 8
);
    logic                  iSpawn;
    logic [8:0]            iRandX;
    logic                  iTick;
    logic [SPEED_W-1:0]    iSpeed;
    logic                  iSalto;
    logic [NUM_CARS*10-1:0] oPosX;
    logic [NUM_CARS*9-1:0]  oPosY;
    logic [NUM_CARS-1:0]   oActive;
    logic                  oSpawnAck;
    logic                  oSpawnRej;
    logic [CNT_W-1:0]      oPassCount;
`ifdef OBSTACLE_COLLISION_EN
    logic [9:0]            iPlayerX;
    logic [8:0]            iPlayerY;
    logic                  oHit;

    modport master (
        output iSpawn, iRandX, iTick, iSpeed, iSalto, iPlayerX, iPlayerY,
        input  oPosX, oPosY, oActive, oSpawnAck, oSpawnRej, oPassCount, oHit
    );
    modport slave (
        input  iSpawn, iRandX, iTick, iSpeed, iSalto, iPlayerX, iPlayerY,
        output oPosX, oPosY, oActive, oSpawnAck, oSpawnRej, oPassCount, oHit
    );
`else
    modport master (
        output iSpawn, iRandX, iTick, iSpeed, iSalto,
        input  oPosX, oPosY, oActive, oSpawnAck, oSpawnRej, oPassCount
    );
    modport slave (
        input  iSpawn, iRandX, iTick, iSpeed, iSalto,
        output oPosX, oPosY, oActive, oSpawnAck, oSpawnRej, oPassCount
    );
`endif
endinterface

// File: rtl/obstacle_slot.sv
// One obstacle car: state, X and Y registers, scrolling and retirement.
//   iClk, iRst_n   clock, asynchronous active-low reset
//   alloc, alloc_x take this slot for a new car at (alloc_x, 0)
//   tick, speed    frame tick and pixels per tick
//   salto          global clear, wins over everything else
//   active         slot holds a car
//   pos_x, pos_y   car position
//   retire         combinational: this tick moves the car off screen
//
// state       | meaning
// ------------+---------------------------------------------
// SLOT_IDLE   | no car; X/Y are 0 or the last retired X with Y=0
// SLOT_ACTIVE | car on screen, scrolls by speed on each tick
module obstacle_slot
    import car_game_pkg::*;
#(
    parameter int SCREEN_H = 480,
    parameter int SPEED_W  = 4
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               alloc,
    input  logic [X_W-1:0]     alloc_x,
    input  logic               tick,
    input  logic [SPEED_W-1:0] speed,
    input  logic               salto,
    output logic               active,
    output logic [X_W-1:0]     pos_x,
    output logic [Y_W-1:0]     pos_y,
    output logic               retire
);
    localparam int YN_W = Y_W + 1;

    logic [0:0]      state;
    logic [YN_W-1:0] y_next;

    // one extra bit so a car near the bottom cannot wrap back to the top
    assign y_next = {1'b0, pos_y} + YN_W'(speed);
    assign active = (state == SLOT_ACTIVE);
    assign retire = tick && active && !salto && (y_next >= YN_W'(SCREEN_H));

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= SLOT_IDLE;
            pos_x <= '0;
            pos_y <= '0;
        end else if (salto) begin
            state <= SLOT_IDLE;
            pos_x <= '0;
            pos_y <= '0;
        end else if (alloc) begin
            // only ever granted to an idle slot, so a same-cycle tick cannot apply
            state <= SLOT_ACTIVE;
            pos_x <= alloc_x;
            pos_y <= '0;
        end else if (retire) begin
            state <= SLOT_IDLE;
            pos_y <= '0;
        end else if (tick && active) begin
            pos_y <= y_next[Y_W-1:0];
        end
    end

endmodule

// File: rtl/obstacle_car_bank.sv
// Bank of NUM_CARS obstacle cars over NUM_LANES lanes, between the random
// generator / game FSM and the sprite renderer.
//   iClk, iRst_n   clock, asynchronous active-low reset
//   bus            obstacle_car_bank_if.slave (spawn, tick, clear, positions,
//                  spawn ack/reject, pass counter)
// Optional feature macro: OBSTACLE_COLLISION_EN adds the player position
// inputs and the registered oHit flag.
module obstacle_car_bank
    import car_game_pkg::*;
#(
    parameter int NUM_CARS   = 4,
    parameter int NUM_LANES  = 2,
    parameter int LANE0_X    = 225,
    parameter int LANE_PITCH = 105,
    parameter int SCREEN_H   = 480,
    parameter int MIN_GAP    = 64,
    parameter int SPEED_W    = 4,
    parameter int CNT_W      = 8
) (
    input  logic                iClk,
    input  logic                iRst_n,
    obstacle_car_bank_if.slave  bus
);
    localparam int SUM_W = 4;  // NUM_CARS <= 8

    logic [NUM_CARS-1:0]     slot_active;
    logic [NUM_CARS-1:0]     slot_retire;
    logic [NUM_CARS-1:0]     free_onehot;
    logic [NUM_CARS-1:0]     alloc_vec;
    logic [X_W-1:0]          slot_x [NUM_CARS];
    logic [Y_W-1:0]          slot_y [NUM_CARS];
    logic                    have_free;
    logic                    gap_block;
    logic                    spawn_ok;
    logic [1:0]              spawn_lane;
    logic [X_W-1:0]          spawn_x;
    logic [SUM_W-1:0]        retire_sum;
    logic [CNT_W+SUM_W-1:0]  pass_sum;
    logic [CNT_W-1:0]        pass_next;
    logic [CNT_W-1:0]        pass_count;
    logic                    spawn_ack;
    logic                    spawn_rej;
    logic [NUM_CARS*X_W-1:0] pos_x_flat;
    logic [NUM_CARS*Y_W-1:0] pos_y_flat;

    assign spawn_lane = lane_of(bus.iRandX, NUM_LANES);
    assign spawn_x    = lane_centre(spawn_lane, LANE0_X, LANE_PITCH);

    // lowest-index idle slot; uses registered state so a slot retiring on
    // this tick is still busy until the next cycle
    always_comb begin
        free_onehot = '0;
        have_free   = 1'b0;
        for (int k = 0; k < NUM_CARS; k++) begin
            if (!slot_active[k] && !have_free) begin
                free_onehot[k] = 1'b1;
                have_free      = 1'b1;
            end
        end
    end

    // lane centres are distinct, so matching X is matching lane; Y is pre-tick
    always_comb begin
        gap_block = 1'b0;
        for (int k = 0; k < NUM_CARS; k++) begin
            if (slot_active[k] && (slot_x[k] == spawn_x) && (slot_y[k] < Y_W'(MIN_GAP))) begin
                gap_block = 1'b1;
            end
        end
    end

    assign spawn_ok  = bus.iSpawn && !bus.iSalto && have_free && !gap_block;
    assign alloc_vec = spawn_ok ? free_onehot : '0;

    for (genvar k = 0; k < NUM_CARS; k++) begin : g_slot
        obstacle_slot #(
            .SCREEN_H (SCREEN_H),
            .SPEED_W  (SPEED_W)
        ) u_slot (
            .iClk    (iClk),
            .iRst_n  (iRst_n),
            .alloc   (alloc_vec[k]),
            .alloc_x (spawn_x),
            .tick    (bus.iTick),
            .speed   (bus.iSpeed),
            .salto   (bus.iSalto),
            .active  (slot_active[k]),
            .pos_x   (slot_x[k]),
            .pos_y   (slot_y[k]),
            .retire  (slot_retire[k])
        );
    end

    always_comb begin
        retire_sum = '0;
        for (int k = 0; k < NUM_CARS; k++) begin
            retire_sum = retire_sum + SUM_W'(slot_retire[k]);
        end
    end

    assign pass_sum  = (CNT_W+SUM_W)'(pass_count) + (CNT_W+SUM_W)'(retire_sum);
    assign pass_next = (|pass_sum[CNT_W+SUM_W-1:CNT_W]) ? {CNT_W{1'b1}} : pass_sum[CNT_W-1:0];

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            spawn_ack  <= 1'b0;
            spawn_rej  <= 1'b0;
            pass_count <= '0;
        end else begin
            spawn_ack  <= spawn_ok;
            spawn_rej  <= bus.iSpawn && !bus.iSalto && !spawn_ok;
            pass_count <= pass_next;
        end
    end

    always_comb begin
        pos_x_flat = '0;
        pos_y_flat = '0;
        for (int k = 0; k < NUM_CARS; k++) begin
            pos_x_flat[k*X_W +: X_W] = slot_x[k];
            pos_y_flat[k*Y_W +: Y_W] = slot_y[k];
        end
    end

    assign bus.oPosX      = pos_x_flat;
    assign bus.oPosY      = pos_y_flat;
    assign bus.oActive    = slot_active;
    assign bus.oSpawnAck  = spawn_ack;
    assign bus.oSpawnRej  = spawn_rej;
    assign bus.oPassCount = pass_count;

`ifdef OBSTACLE_COLLISION_EN
    logic hit_any;
    logic hit_q;

    always_comb begin
        hit_any = 1'b0;
        for (int k = 0; k < NUM_CARS; k++) begin
            if (slot_active[k] && (slot_x[k] == bus.iPlayerX) &&
                (y_dist(slot_y[k], bus.iPlayerY) < Y_W'(32))) begin
                hit_any = 1'b1;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_any;
        end
    end

    assign bus.oHit = hit_q;
`endif

endmodule

// File: tb/tb_obstacle_car_bank.sv
module tb_obstacle_car_bank;

    typedef struct packed {
        logic [39:0] x;
        logic [35:0] y;
        logic [3:0]  act;
        logic        ack;
        logic        rej;
        logic [7:0]  cnt;
    } snap_t;

    logic clk;
    logic rst_n;

    obstacle_car_bank_if #(.NUM_CARS(4), .SPEED_W(4), .CNT_W(8)) bus ();

    obstacle_car_bank dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // reference model of the bank
    int m_act [4];
    int m_x   [4];
    int m_y   [4];
    int m_lane[4];
    int m_cnt;

    snap_t exp_q[$];
    snap_t obs_q[$];
    snap_t e;
    snap_t o;

    function automatic snap_t observe();
        snap_t s;
        s.x   = bus.oPosX;
        s.y   = bus.oPosY;
        s.act = bus.oActive;
        s.ack = bus.oSpawnAck;
        s.rej = bus.oSpawnRej;
        s.cnt = bus.oPassCount;
        return s;
    endfunction

    task automatic model_clear(input bit clr_cnt);
        for (int k = 0; k < 4; k++) begin
            m_act[k] = 0; m_x[k] = 0; m_y[k] = 0; m_lane[k] = 0;
        end
        if (clr_cnt) m_cnt = 0;
    endtask

    // drive one cycle, predict its outcome, capture what the DUT shows
    task automatic do_cycle(input bit spawn, input int rx, input bit tick, input int spd, input bit salto);
        snap_t x;
        int pre_act[4];
        int pre_y[4];
        int lane, nx, free, s;
        bit gap, ack, rej;
        ack = 0; rej = 0;
        for (int k = 0; k < 4; k++) begin pre_act[k] = m_act[k]; pre_y[k] = m_y[k]; end
        if (salto) begin
            model_clear(0);
        end else begin
            lane = (rx * 2) >> 9;
            nx   = 225 + lane * 105;
            free = -1;
            gap  = 0;
            for (int k = 0; k < 4; k++) begin
                if (pre_act[k] == 0 && free < 0) free = k;
                if (pre_act[k] != 0 && m_lane[k] == lane && pre_y[k] < 64) gap = 1;
            end
            if (tick) begin
                for (int k = 0; k < 4; k++) begin
                    if (pre_act[k] != 0) begin
                        s = pre_y[k] + spd;
                        if (s >= 480) begin
                            m_act[k] = 0; m_y[k] = 0;
                            if (m_cnt < 255) m_cnt++;
                        end else begin
                            m_y[k] = s;
                        end
                    end
                end
            end
            if (spawn) begin
                if (free >= 0 && !gap) begin
                    m_act[free] = 1; m_x[free] = nx; m_y[free] = 0; m_lane[free] = lane;
                    ack = 1;
                end else begin
                    rej = 1;
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            x.x[k*10 +: 10] = 10'(m_x[k]);
            x.y[k*9 +: 9]   = 9'(m_y[k]);
            x.act[k]        = (m_act[k] != 0);
        end
        x.ack = ack;
        x.rej = rej;
        x.cnt = 8'(m_cnt);
        exp_q.push_back(x);

        bus.iSpawn = spawn;
        bus.iRandX = 9'(rx);
        bus.iTick  = tick;
        bus.iSpeed = 4'(spd);
        bus.iSalto = salto;
        @(posedge clk);
        #1;
        bus.iSpawn = 1'b0;
        bus.iTick  = 1'b0;
        bus.iSalto = 1'b0;
        obs_q.push_back(observe());
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_total++;
        if (observe() !== '0) $display("FAIL reset_outputs: got %h want 0", observe());
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (bus.oActive !== 4'b0000 || bus.oPassCount !== 8'd0)
            $display("FAIL reset_release: got act=%b cnt=%0d want act=0000 cnt=0", bus.oActive, bus.oPassCount);
        else n_pass++;
    endtask

    task automatic test_spawn_lanes();
        do_cycle(1, 100, 0, 0, 0);
        do_cycle(1, 300, 0, 0, 0);
        n_total++;
        if (bus.oPosX[19:0] !== {10'd330, 10'd225} || bus.oActive !== 4'b0011)
            $display("FAIL lane_x: got x1=%0d x0=%0d act=%b want x1=330 x0=225 act=0011",
                     bus.oPosX[19:10], bus.oPosX[9:0], bus.oActive);
        else n_pass++;
        do_cycle(0, 0, 0, 0, 1);
        do_cycle(1, 255, 0, 0, 0);
        do_cycle(1, 256, 0, 0, 0);
        n_total++;
        if (bus.oPosX[19:0] !== {10'd330, 10'd225})
            $display("FAIL lane_edge: got x1=%0d x0=%0d want x1=330 x0=225", bus.oPosX[19:10], bus.oPosX[9:0]);
        else n_pass++;
        do_cycle(1, 100, 0, 0, 1);
        n_total++;
        if (bus.oSpawnAck !== 1'b0 || bus.oSpawnRej !== 1'b0 || bus.oActive !== 4'b0000)
            $display("FAIL salto_drop: got ack=%b rej=%b act=%b want 0 0 0000", bus.oSpawnAck, bus.oSpawnRej, bus.oActive);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
            if (o !== e)
                $display("FAIL spawn_lanes: got act=%b ack=%b rej=%b cnt=%0d x=%h y=%h want act=%b ack=%b rej=%b cnt=%0d x=%h y=%h",
                         o.act, o.ack, o.rej, o.cnt, o.x, o.y, e.act, e.ack, e.rej, e.cnt, e.x, e.y);
            else n_pass++;
        end
    endtask

    task automatic test_gap_reject();
        do_cycle(1, 10, 0, 0, 0);
        do_cycle(1, 10, 0, 0, 0);
        n_total++;
        if (bus.oSpawnRej !== 1'b1 || bus.oSpawnAck !== 1'b0 || bus.oActive !== 4'b0001)
            $display("FAIL gap_reject: got rej=%b ack=%b act=%b want 1 0 0001", bus.oSpawnRej, bus.oSpawnAck, bus.oActive);
        else n_pass++;
        do_cycle(0, 0, 0, 0, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
            if (o !== e)
                $display("FAIL gap_seq: got act=%b ack=%b rej=%b cnt=%0d x=%h y=%h want act=%b ack=%b rej=%b cnt=%0d x=%h y=%h",
                         o.act, o.ack, o.rej, o.cnt, o.x, o.y, e.act, e.ack, e.rej, e.cnt, e.x, e.y);
            else n_pass++;
        end
    endtask

    task automatic test_retire();
        do_cycle(1, 10, 0, 0, 0);
        do_cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 47; i++) do_cycle(0, 0, 1, 10, 0);
        n_total++;
        if (bus.oPosY[8:0] !== 9'd470 || bus.oActive[0] !== 1'b1)
            $display("FAIL y470: got y=%0d act=%b want 470 1", bus.oPosY[8:0], bus.oActive[0]);
        else n_pass++;
        do_cycle(0, 0, 1, 10, 0);
        n_total++;
        if (bus.oActive[0] !== 1'b0 || bus.oPassCount !== 8'd1 || bus.oPosY[8:0] !== 9'd0)
            $display("FAIL retire_480: got act=%b cnt=%0d y=%0d want 0 1 0", bus.oActive[0], bus.oPassCount, bus.oPosY[8:0]);
        else n_pass++;
        do_cycle(1, 10, 0, 0, 0);
        for (int i = 0; i < 46; i++) do_cycle(0, 0, 1, 10, 0);
        do_cycle(0, 0, 1, 9, 0);
        do_cycle(0, 0, 1, 10, 0);
        n_total++;
        if (bus.oPosY[8:0] !== 9'd479 || bus.oActive[0] !== 1'b1 || bus.oPassCount !== 8'd1)
            $display("FAIL stay_479: got y=%0d act=%b cnt=%0d want 479 1 1", bus.oPosY[8:0], bus.oActive[0], bus.oPassCount);
        else n_pass++;
        do_cycle(0, 0, 1, 1, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
            if (o !== e)
                $display("FAIL retire_seq: got act=%b ack=%b rej=%b cnt=%0d x=%h y=%h want act=%b ack=%b rej=%b cnt=%0d x=%h y=%h",
                         o.act, o.ack, o.rej, o.cnt, o.x, o.y, e.act, e.ack, e.rej, e.cnt, e.x, e.y);
            else n_pass++;
        end
    endtask

    task automatic test_full_and_spawn_tick();
        do_cycle(1, 100, 0, 0, 0);
        do_cycle(1, 300, 0, 0, 0);
        for (int i = 0; i < 5; i++) do_cycle(0, 0, 1, 15, 0);
        do_cycle(1, 100, 0, 0, 0);
        do_cycle(1, 300, 0, 0, 0);
        for (int i = 0; i < 5; i++) do_cycle(0, 0, 1, 15, 0);
        do_cycle(1, 100, 0, 0, 0);
        n_total++;
        if (bus.oSpawnRej !== 1'b1 || bus.oActive !== 4'b1111)
            $display("FAIL full_reject: got rej=%b act=%b want 1 1111", bus.oSpawnRej, bus.oActive);
        else n_pass++;
        for (int i = 0; i < 21; i++) do_cycle(0, 0, 1, 15, 0);
        do_cycle(1, 100, 1, 15, 0);
        n_total++;
        if (bus.oSpawnRej !== 1'b1 || bus.oActive !== 4'b1100)
            $display("FAIL freed_not_reused: got rej=%b act=%b want 1 1100", bus.oSpawnRej, bus.oActive);
        else n_pass++;
        do_cycle(1, 100, 1, 15, 0);
        n_total++;
        if (bus.oSpawnAck !== 1'b1 || bus.oPosY[8:0] !== 9'd0 || bus.oPosX[9:0] !== 10'd225 ||
            bus.oPosY[26:18] !== 9'd420 || bus.oActive !== 4'b1101)
            $display("FAIL spawn_tick: got ack=%b y0=%0d x0=%0d y2=%0d act=%b want 1 0 225 420 1101",
                     bus.oSpawnAck, bus.oPosY[8:0], bus.oPosX[9:0], bus.oPosY[26:18], bus.oActive);
        else n_pass++;
        do_cycle(0, 0, 0, 0, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
            if (o !== e)
                $display("FAIL full_seq: got act=%b ack=%b rej=%b cnt=%0d x=%h y=%h want act=%b ack=%b rej=%b cnt=%0d x=%h y=%h",
                         o.act, o.ack, o.rej, o.cnt, o.x, o.y, e.act, e.ack, e.rej, e.cnt, e.x, e.y);
            else n_pass++;
        end
    endtask

    task automatic test_saturation_salto();
        int i;
        i = 0;
        while (i < 6000 && m_cnt < 253) begin
            do_cycle(1, (i % 2 == 1) ? 300 : 100, 1, 15, 0);
            i++;
        end
        n_total++;
        if (bus.oPassCount < 8'd253)
            $display("FAIL count_build: got %0d want at least 253 within 6000 cycles", bus.oPassCount);
        else n_pass++;
        for (int r = 0; r < 2; r++) begin
            do_cycle(0, 0, 0, 0, 1);
            do_cycle(1, 100, 0, 0, 0);
            do_cycle(1, 300, 0, 0, 0);
            for (int t = 0; t < 32; t++) do_cycle(0, 0, 1, 15, 0);
        end
        n_total++;
        if (bus.oPassCount !== 8'd255 || bus.oActive !== 4'b0000)
            $display("FAIL saturate: got cnt=%0d act=%b want 255 0000", bus.oPassCount, bus.oActive);
        else n_pass++;
        do_cycle(1, 100, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 1);
        n_total++;
        if (bus.oActive !== 4'b0000 || bus.oPassCount !== 8'd255 || bus.oPosX !== 40'd0)
            $display("FAIL salto_keep: got act=%b cnt=%0d x=%h want 0000 255 0", bus.oActive, bus.oPassCount, bus.oPosX);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
            if (o !== e)
                $display("FAIL sat_seq: got act=%b ack=%b rej=%b cnt=%0d x=%h y=%h want act=%b ack=%b rej=%b cnt=%0d x=%h y=%h",
                         o.act, o.ack, o.rej, o.cnt, o.x, o.y, e.act, e.ack, e.rej, e.cnt, e.x, e.y);
            else n_pass++;
        end
    endtask

`ifdef OBSTACLE_COLLISION_EN
    task automatic test_collision();
        bus.iPlayerX = 10'd225;
        bus.iPlayerY = 9'd420;
        do_cycle(1, 10, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 0);
        n_total++;
        if (bus.oHit !== 1'b0) $display("FAIL hit_far: got %b want 0", bus.oHit);
        else n_pass++;
        for (int t = 0; t < 40; t++) do_cycle(0, 0, 1, 10, 0);
        do_cycle(0, 0, 0, 0, 0);
        n_total++;
        if (bus.oHit !== 1'b1) $display("FAIL hit_near: got %b want 1", bus.oHit);
        else n_pass++;
        do_cycle(0, 0, 0, 0, 1);
        exp_q.delete();
        obs_q.delete();
    endtask
`endif

    task automatic test_async_reset();
        do_cycle(1, 100, 0, 0, 0);
        do_cycle(1, 300, 1, 5, 0);
        do_cycle(0, 0, 1, 5, 0);
        bus.iTick  = 1'b1;
        bus.iSpeed = 4'd5;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (observe() !== '0) $display("FAIL async_reset: got %h want 0", observe());
        else n_pass++;
        bus.iTick = 1'b0;
        #3;
        rst_n = 1'b1;
        model_clear(1);
        exp_q.delete();
        obs_q.delete();
        do_cycle(1, 300, 0, 0, 0);
        n_total++;
        if (bus.oActive !== 4'b0001 || bus.oPosX[9:0] !== 10'd330 || bus.oPassCount !== 8'd0)
            $display("FAIL post_reset: got act=%b x0=%0d cnt=%0d want 0001 330 0", bus.oActive, bus.oPosX[9:0], bus.oPassCount);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
            if (o !== e)
                $display("FAIL reset_seq: got act=%b ack=%b rej=%b cnt=%0d x=%h y=%h want act=%b ack=%b rej=%b cnt=%0d x=%h y=%h",
                         o.act, o.ack, o.rej, o.cnt, o.x, o.y, e.act, e.ack, e.rej, e.cnt, e.x, e.y);
            else n_pass++;
        end
    endtask

    initial begin
        bus.iSpawn = 1'b0;
        bus.iRandX = 9'd0;
        bus.iTick  = 1'b0;
        bus.iSpeed = 4'd0;
        bus.iSalto = 1'b0;
`ifdef OBSTACLE_COLLISION_EN
        bus.iPlayerX = 10'd0;
        bus.iPlayerY = 9'd0;
`endif
        model_clear(1);
        test_reset();
        test_spawn_lanes();
        test_gap_reject();
        test_retire();
        test_full_and_spawn_tick();
        test_saturation_salto();
`ifdef OBSTACLE_COLLISION_EN
        test_collision();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
